dac_spi: RTL and testbench

DAC_SPI -- requirements
Module: dac_spi

---
 rtl/dac_spi_pkg.sv | 21 ++
 rtl/dac_spi.sv | 127 ++++++++++++
 tb/tb_dac_spi.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
// Shared DAC SPI constants: frame geometry, FSM state encoding and the chip-select budget
// that the acquisition block also uses for its gain-update window.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  localparam int DAC_DATA_W_DEF  = 10;
  localparam int DAC_SCK_DIV_DEF = 8;

  // Four config bits ahead of the code and two zero bits after it.
  localparam int FRAME_PAD_W = 6;
  localparam int FRAME_W     = DAC_DATA_W_DEF + FRAME_PAD_W;

  // cs_n low time at the default parameters; must not grow.
  localparam int CS_LOW_CYCLES = FRAME_W * DAC_SCK_DIV_DEF;

endpackage

// File: rtl/dac_spi.sv
// SPI mode-0 DAC writer: first bit one cycle after dvalid, one frame every FRAME_W*DIV+DIV/2+1 cycles.
// dvalid is never stalled; a code arriving mid-frame waits in a one-deep register where the latest wins.
module dac_spi
  import dac_spi_pkg::*;
#(
  parameter int         DAC_DATA_W  = 10,
  parameter int         DAC_SCK_DIV = 8,
  parameter logic [3:0] DAC_CFG     = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_DATA_W-1:0] din,
  input  logic                  dvalid,
  output logic                  busy,
  output logic                  done,
  output logic                  dac_sck,
  output logic                  dac_cs_n,
  output logic                  dac_mosi
);

  localparam int FW    = DAC_DATA_W + FRAME_PAD_W;
  localparam int DIV_W = $clog2(DAC_SCK_DIV);
  localparam int BIT_W = $clog2(FW);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DAC_SCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DAC_SCK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FW-1:0]           shreg;
  logic [DAC_DATA_W-1:0]   pend_dat;
  logic                    pending;

  logic                    div_last;
  logic                    div_half;
  logic                    bit_last;
  logic                    launch;
  logic [DAC_DATA_W-1:0]   launch_dat;

  logic                    cs_n_nxt;
  logic                    sck_nxt;
  logic                    done_nxt;
  logic                    busy_nxt;
  logic                    pending_nxt;

  assign div_last   = (div_cnt == DIV_LAST);
  assign div_half   = (div_cnt == DIV_HALF);
  assign bit_last   = (bit_cnt == BIT_LAST);
  assign launch     = (state == ST_IDLE) && (dvalid || pending);
  assign launch_dat = pending ? pend_dat : din;

  // MSB of the shifter is a flop output; it drains to zero once the frame is out.
  assign dac_mosi = shreg[FW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (launch)               state_nxt = ST_SHIFT;
      ST_SHIFT: if (div_last && bit_last) state_nxt = ST_END;
      ST_END:   if (div_half)             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_n_nxt    = (state_nxt != ST_SHIFT);
    sck_nxt     = (state == ST_SHIFT) && !div_last && (div_half || dac_sck);
    done_nxt    = (state == ST_SHIFT) && div_last && bit_last;
    // In IDLE a stored code is launched now, so only a fresh dvalid stays pending.
    pending_nxt = (state == ST_IDLE) ? (pending && dvalid) : (pending || dvalid);
    busy_nxt    = (state_nxt != ST_IDLE) || pending_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_cs_n <= 1'b1;
      dac_sck  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      pending  <= 1'b0;
      pend_dat <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      dac_cs_n <= cs_n_nxt;
      dac_sck  <= sck_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      pending  <= pending_nxt;

      if (dvalid && ((state != ST_IDLE) || pending)) begin
        pend_dat <= din;
      end

      if (launch) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= {DAC_CFG, launch_dat, 2'b00};
      end else if (state == ST_SHIFT) begin
        if (div_last) begin
          div_cnt <= '0;
          shreg   <= {shreg[FW-2:0], 1'b0};
          if (!bit_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else if (state == ST_END) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_spi.sv
// Two DAC writers (SCK divider 8 and 2) share one stimulus and are checked every cycle
// against a frame-timing model plus literal expectations for the directed scenarios.
module tb_dac_spi;

  localparam int FW   = 16;
  localparam int DIV0 = 8;
  localparam int DIV1 = 2;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       dvalid = 1'b0;
  logic [9:0] din    = '0;

  logic busy0, done0, sck0, cs_n0, mosi0;
  logic busy1, done1, sck1, cs_n1, mosi1;

  always #5 clk = ~clk;

  dac_spi #(.DAC_DATA_W(10), .DAC_SCK_DIV(DIV0), .DAC_CFG(4'b0011)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .dvalid(dvalid),
    .busy(busy0), .done(done0), .dac_sck(sck0), .dac_cs_n(cs_n0), .dac_mosi(mosi0)
  );

  dac_spi #(.DAC_DATA_W(10), .DAC_SCK_DIV(DIV1), .DAC_CFG(4'b0011)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .dvalid(dvalid),
    .busy(busy1), .done(done1), .dac_sck(sck1), .dac_cs_n(cs_n1), .dac_mosi(mosi1)
  );

  int n_tot = 0;
  int n_pass = 0;
  int ncyc = 0;

  logic       s_dvalid;
  logic       s_rst;
  logic [9:0] s_din;

  always @(posedge clk) begin
    s_dvalid <= dvalid;
    s_din    <= din;
    s_rst    <= rst;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, got, want, ncyc);
  endtask

  function automatic logic [15:0] mk_frame(input logic [9:0] d);
    return {4'b0011, d, 2'b00};
  endfunction

  // Model: a frame launched from cycle t0 owns cycles t0+1 .. t0+FW*D+D/2, then one idle cycle.
  int         div_of [2] = '{DIV0, DIV1};
  bit         m_act  [2];
  int         m_t0   [2];
  logic [15:0] m_frame [2];
  bit         m_pend [2];
  logic [9:0] m_pdat [2];

  task automatic model_step(input int id);
    int d, l, rprev;
    d = div_of[id];
    l = FW * d + d / 2;
    if (rst || s_rst) begin
      m_act[id]  = 0;
      m_pend[id] = 0;
    end else begin
      rprev = ncyc - 1 - m_t0[id];
      if (!m_act[id] || rprev > l) begin
        if (m_pend[id]) begin
          m_t0[id]    = ncyc - 1;
          m_frame[id] = mk_frame(m_pdat[id]);
          m_act[id]   = 1;
          m_pend[id]  = s_dvalid;
          m_pdat[id]  = s_din;
        end else if (s_dvalid) begin
          m_t0[id]    = ncyc - 1;
          m_frame[id] = mk_frame(s_din);
          m_act[id]   = 1;
        end
      end else if (s_dvalid) begin
        m_pend[id] = 1;
        m_pdat[id] = s_din;
      end
    end
  endtask

  task automatic check_cycle(input int id, input logic cs_n, input logic sck, input logic mosi,
                             input logic dn, input logic bsy);
    int d, r, l;
    bit inf;
    d   = div_of[id];
    l   = FW * d + d / 2;
    r   = ncyc - m_t0[id];
    inf = m_act[id] && r >= 1 && r <= FW * d;
    chk($sformatf("cs_n%0d", id), cs_n, inf ? 0 : 1);
    chk($sformatf("sck%0d", id), sck, (inf && ((r - 1) % d >= d / 2)) ? 1 : 0);
    if (inf) chk($sformatf("mosi%0d", id), mosi, m_frame[id][FW - 1 - (r - 1) / d]);
    chk($sformatf("done%0d", id), dn, (m_act[id] && r == FW * d + 1) ? 1 : 0);
    chk($sformatf("busy%0d", id), bsy, ((m_act[id] && r >= 1 && r <= l) || m_pend[id]) ? 1 : 0);
  endtask

  // Monitor: reconstruct frames from the pins for the directed literal checks.
  logic        prev_cs   [2] = '{1'b1, 1'b1};
  logic        prev_sck  [2] = '{1'b0, 1'b0};
  logic        prev_busy [2] = '{1'b0, 1'b0};
  logic [15:0] cap       [2];
  int          rises [2], len [2], last_len [2], last_rises [2];
  int          done_cyc [2], tot_rises [2], busy_falls [2];
  logic [15:0] frames0 [$];
  logic [15:0] frames1 [$];
  int          falls0 [$];

  task automatic monitor(input int id, input logic cs_n, input logic sck, input logic mosi,
                         input logic dn, input logic bsy);
    if (!cs_n && prev_cs[id]) begin
      cap[id]   = '0;
      rises[id] = 0;
      len[id]   = 0;
      if (id == 0) falls0.push_back(ncyc);
    end
    if (!cs_n) len[id]++;
    if (sck && !prev_sck[id] && !cs_n) begin
      cap[id] = {cap[id][14:0], mosi};
      rises[id]++;
      tot_rises[id]++;
    end
    if (cs_n && !prev_cs[id]) begin
      if (id == 0) frames0.push_back(cap[id]);
      else         frames1.push_back(cap[id]);
      last_len[id]   = len[id];
      last_rises[id] = rises[id];
    end
    if (dn) done_cyc[id] = ncyc;
    if (!bsy && prev_busy[id]) busy_falls[id]++;
    prev_cs[id]   = cs_n;
    prev_sck[id]  = sck;
    prev_busy[id] = bsy;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      model_step(0);
      model_step(1);
      check_cycle(0, cs_n0, sck0, mosi0, done0, busy0);
      check_cycle(1, cs_n1, sck1, mosi1, done1, busy1);
      monitor(0, cs_n0, sck0, mosi0, done0, busy0);
      monitor(1, cs_n1, sck1, mosi1, done1, busy1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the spec's cycle 0, i.e. the cycle whose closing edge samples dvalid.
  task automatic pulse(input logic [9:0] v, output int t0);
    dvalid = 1'b1;
    din    = v;
    @(posedge clk);
    t0 = ncyc;
    #1;
    dvalid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy0 && !busy1) begin
        ok = 1;
        break;
      end
      step(1);
    end
    chk({nm, "_timeout"}, ok, 1);
    step(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int t0, t1, nf0, nf1, r0, bf;
    rst = 1'b1;
    step(3);
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_sck", sck0, 0);
    chk("rst_mosi", mosi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cs_n_div2", cs_n1, 1);
    rst = 1'b0;
    step(3);

    pulse(10'h2A5, t0);
    wait_idle("single");
    chk("single_word", frames0[$], 16'h3A94);
    chk("single_rises", last_rises[0], 16);
    chk("single_cs_low", last_len[0], 128);
    chk("single_done_cyc", done_cyc[0] - t0, 129);
    chk("single_fall_cyc", falls0[$] - t0, 1);
    chk("single_word_div2", frames1[$], 16'h3A94);

    bf = busy_falls[0];
    pulse(10'h001, t0);
    step(19);
    pulse(10'h3FF, t1);
    wait_idle("b2b");
    chk("b2b_first", frames0[$-1], 16'h3004);
    chk("b2b_second", frames0[$], 16'h3FFC);
    chk("b2b_start_cyc", falls0[$] - t0, 134);
    chk("b2b_busy_falls", busy_falls[0] - bf, 1);

    nf0 = frames0.size();
    nf1 = frames1.size();
    pulse(10'd1, t0);
    step(9);
    pulse(10'd2, t1);
    step(39);
    pulse(10'd3, t1);
    wait_idle("ovw");
    chk("ovw_count", frames0.size() - nf0, 2);
    chk("ovw_first", frames0[nf0], 16'h3004);
    chk("ovw_second", frames0[nf0 + 1], 16'h300C);
    chk("ovw_count_div2", frames1.size() - nf1, 3);

    pulse(10'h155, t0);
    wait_idle("div2");
    chk("div2_word", frames1[$], 16'h3554);
    chk("div2_cs_low", last_len[1], 32);
    chk("div2_rises", last_rises[1], 16);
    chk("div2_done_cyc", done_cyc[1] - t0, 33);
    chk("div8_word_155", frames0[$], 16'h3554);

    pulse(10'h2A5, t0);
    step(59);
    rst = 1'b1;
    #1;
    chk("abort_cs_n", cs_n0, 1);
    chk("abort_sck", sck0, 0);
    chk("abort_busy", busy0, 0);
    r0 = tot_rises[0];
    step(3);
    rst = 1'b0;
    step(300);
    chk("abort_no_sck", tot_rises[0] - r0, 0);
    chk("abort_cs_idle", cs_n0, 1);
    chk("abort_busy_idle", busy0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
